// File: rtl/riscv_hwloop_unit.sv
// riscv_hwloop_unit: RI5CY hardware-loop unit (register file, end-of-body
// match, target select, counter commit on the ID handshake, exit pulse).
// Optional feature macro: HWLP_PERF_CNT_EN adds hwlp_perf_jumps_o, a count
// of taken loop-back jumps.

// Per-loop state: start/end addresses, iteration counter, exit flag.
module riscv_hwloop_reg #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [2:0]       we_i,
    input  logic [31:0]      start_data_i,
    input  logic [31:0]      end_data_i,
    input  logic [CNT_W-1:0] cnt_data_i,
    input  logic             dec_i,
    output logic [31:0]      start_o,
    output logic [31:0]      end_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             exit_o
);

    // Address registers; bit 0 is always cleared (instructions are halfword aligned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_o <= '0;
            end_o   <= '0;
        end else begin
            if (we_i[0]) start_o <= {start_data_i[31:1], 1'b0};
            if (we_i[1]) end_o   <= {end_data_i[31:1], 1'b0};
        end
    end

    // Counter: flush beats a CSR write, which beats the handshake decrement.
    // dec_i is only raised for a matching loop, so cnt_o is non-zero here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o  <= '0;
            exit_o <= 1'b0;
        end else if (flush_i) begin
            cnt_o  <= '0;
            exit_o <= 1'b0;
        end else begin
            if (we_i[2])    cnt_o <= cnt_data_i;
            else if (dec_i) cnt_o <= cnt_o - CNT_W'(1);
            exit_o <= dec_i & ~we_i[2] & (cnt_o == CNT_W'(1));
        end
    end

endmodule

module riscv_hwloop_unit #(
    parameter int N_LOOPS = 2,
    parameter int CNT_W   = 32,
    localparam int RID_W  = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [31:0]                     current_pc_i,
    input  logic                            pc_valid_i,
    input  logic                            id_ready_i,
    input  logic                            flush_i,
    input  logic [2:0]                      hwlp_we_i,
    input  logic [RID_W-1:0]                hwlp_regid_i,
    input  logic [31:0]                     hwlp_start_data_i,
    input  logic [31:0]                     hwlp_end_data_i,
    input  logic [CNT_W-1:0]                hwlp_cnt_data_i,
    output logic                            hwlp_jump_o,
    output logic [31:0]                     hwlp_targ_addr_o,
    output logic [N_LOOPS-1:0][31:0]        hwlp_start_o,
    output logic [N_LOOPS-1:0][31:0]        hwlp_end_o,
    output logic [N_LOOPS-1:0][CNT_W-1:0]   hwlp_cnt_o,
    output logic [N_LOOPS-1:0]              hwlp_active_o,
`ifdef HWLP_PERF_CNT_EN
    output logic [31:0]                     hwlp_perf_jumps_o,
`endif
    output logic [N_LOOPS-1:0]              hwlp_exit_o
);

    logic [N_LOOPS-1:0] match;
    logic [N_LOOPS-1:0] sel_oh;
    logic [31:0]        sel_start;
    logic [CNT_W-1:0]   sel_cnt;
    logic               found;
    logic               hs;

    assign hs = pc_valid_i & id_ready_i;

    for (genvar i = 0; i < N_LOOPS; i++) begin : g_loop
        logic [2:0] we_loop;
        // Out-of-range indices never compare equal, so such writes drop out.
        assign we_loop = hwlp_we_i & {3{hwlp_regid_i == RID_W'(i)}};
        assign match[i] = pc_valid_i & (current_pc_i == hwlp_end_o[i]) &
                          (hwlp_cnt_o[i] != '0);
        assign hwlp_active_o[i] = (hwlp_cnt_o[i] != '0);

        riscv_hwloop_reg #(.CNT_W(CNT_W)) u_reg (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush_i      (flush_i),
            .we_i         (we_loop),
            .start_data_i (hwlp_start_data_i),
            .end_data_i   (hwlp_end_data_i),
            .cnt_data_i   (hwlp_cnt_data_i),
            .dec_i        (hs & sel_oh[i]),
            .start_o      (hwlp_start_o[i]),
            .end_o        (hwlp_end_o[i]),
            .cnt_o        (hwlp_cnt_o[i]),
            .exit_o       (hwlp_exit_o[i])
        );
    end

    // Lowest matching index (innermost loop) wins; scan downward so it lands last.
    always_comb begin
        sel_oh    = '0;
        sel_start = '0;
        sel_cnt   = '0;
        found     = 1'b0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_start = hwlp_start_o[i];
                sel_cnt   = hwlp_cnt_o[i];
                found     = 1'b1;
            end
        end
    end

    // Last iteration (cnt==1) falls through; a stalled ID keeps the jump asserted.
    assign hwlp_jump_o      = found & (sel_cnt > CNT_W'(1));
    assign hwlp_targ_addr_o = hwlp_jump_o ? sel_start : 32'h0;

`ifdef HWLP_PERF_CNT_EN
    // Taken loop-back jumps, counted once per accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  hwlp_perf_jumps_o <= '0;
        else if (flush_i)            hwlp_perf_jumps_o <= '0;
        else if (hs & hwlp_jump_o)   hwlp_perf_jumps_o <= hwlp_perf_jumps_o + 32'd1;
    end
`endif

endmodule
